// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {RUN, LEN, HI, LO, WR, CS, DONE, ERR} loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         CSUM_W        = 8;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts while enabled, restarts on clear, flags the last allowed cycle.
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYC = 27_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || clear) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Arbitrates the instruction BSRAM between CPU fetch and a UART program-load frame.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int          ADDR_W      = 11,
    parameter int          DATA_W      = 16,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_CYC = 27_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    output logic              cpu_hold,
    output logic              cpu_restart,
    output logic              load_ok,
    output logic              load_err,
    output logic [7:0]        words_loaded
);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] load_addr;
    logic [CSUM_W-1:0] sum;
    logic [7:0]        n_words;
    logic [7:0]        hi_byte;
    logic [7:0]        wl_inc;
    logic              cpu_owns;
    logic              timeout_hit;
    logic              is_sync;

    assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
    assign wl_inc   = words_loaded + 8'd1;
    assign cpu_owns = (state == RUN) || (state == ERR) || (state == DONE);

    assign mem_ce      = 1'b1;
    assign mem_wre     = (state == WR);
    assign mem_ad      = cpu_owns ? cpu_pc : load_addr;
    assign cpu_restart = (state == DONE);

    loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (!cpu_owns),
        .clear   (rx_valid),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: assigning state_next before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN, ERR: if (is_sync) state_next = LEN;
            LEN: begin
                if (rx_valid)         state_next = (rx_data == 8'd0) ? ERR : HI;
                else if (timeout_hit) state_next = ERR;
            end
            HI: begin
                if (rx_valid)         state_next = LO;
                else if (timeout_hit) state_next = ERR;
            end
            LO: begin
                if (rx_valid)         state_next = WR;
                else if (timeout_hit) state_next = ERR;
            end
            WR: begin
                if (rx_valid)               state_next = ERR;
                else if (wl_inc == n_words) state_next = CS;
                else                        state_next = HI;
            end
            CS: begin
                if (rx_valid)         state_next = (rx_data == sum) ? DONE : ERR;
                else if (timeout_hit) state_next = ERR;
            end
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_addr    <= '0;
            sum          <= '0;
            n_words      <= '0;
            hi_byte      <= '0;
            mem_din      <= '0;
            cpu_hold     <= 1'b0;
            load_ok      <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            unique case (state)
                RUN, ERR: begin
                    if (is_sync) begin
                        cpu_hold     <= 1'b1;
                        load_ok      <= 1'b0;
                        load_err     <= 1'b0;
                        words_loaded <= '0;
                        load_addr    <= '0;
                        sum          <= '0;
                    end
                end
                LEN: begin
                    if (rx_valid && rx_data != 8'd0) begin
                        n_words <= rx_data;
                        sum     <= rx_data;
                    end
                end
                HI: begin
                    if (rx_valid) begin
                        hi_byte <= rx_data;
                        sum     <= sum + rx_data;
                    end
                end
                LO: begin
                    if (rx_valid) begin
                        mem_din <= DATA_W'({hi_byte, rx_data});
                        sum     <= sum + rx_data;
                    end
                end
                WR: begin
                    load_addr    <= load_addr + 1'b1;
                    words_loaded <= wl_inc;
                end
                DONE: begin
                    cpu_hold <= 1'b0;
                    load_ok  <= 1'b1;
                end
                default: ;
            endcase
            // Flag the failure on the edge that enters ERR so it is visible immediately.
            if (state_next == ERR && state != ERR) load_err <= 1'b1;
        end
    end

endmodule
